// File: rtl/posit_pkg.sv
// Shared posit types and helpers: decoded-operand record, special bit patterns, scale width.
package posit_pkg;

  function automatic int scale_width(input int n, input int es);
    return $clog2(2 * n * (1 << es)) + 2;
  endfunction

  // Sized for the largest legal configuration (N=32, ES=3) so one struct fits every build.
  localparam int SCALE_W = scale_width(32, 3);
  localparam int SIG_W   = 30;

  typedef struct packed {
    logic                      nar;
    logic                      zero;
    logic                      sign;
    logic signed [SCALE_W-1:0] scale;
    logic [SIG_W-1:0]          sig;
  } dec_t;

  function automatic logic [31:0] nar_pat(input int n);
    return 32'h1 << (n - 1);
  endfunction

  function automatic logic [31:0] maxpos_pat(input int n);
    return (32'h1 << (n - 1)) - 32'h1;
  endfunction

  function automatic logic [31:0] minpos_pat(input int n);
    return (n > 0) ? 32'h1 : 32'h0;
  endfunction

endpackage

// File: rtl/posit_decode.sv
// Combinational posit field extraction for one operand: flags, sign, scale, significand with hidden bit.
module posit_decode
  import posit_pkg::*;
#(
  parameter int N  = 16,
  parameter int ES = 1
) (
  input  logic [N-1:0] x,
  output dec_t         d
);

  logic [N-1:0]              mag;
  logic [N-2:0]              body;
  logic [N-2:0]              rem;
  logic signed [SCALE_W-1:0] k;
  logic                      done;
  int                        m;

  always_comb begin
    mag  = x[N-1] ? -x : x;
    body = (N-1)'(mag);
    m    = 0;
    done = 1'b0;
    for (int i = N - 2; i >= 0; i--) begin
      if (!done && (body[i] == body[N-2])) m = m + 1;
      else done = 1'b1;
    end
    k   = body[N-2] ? SCALE_W'(m - 1) : -SCALE_W'(m);
    // Drop the regime run and its terminator; exponent then fraction are left-aligned.
    rem = body << (m + 1);

    d.nar   = (x == N'(nar_pat(N)));
    d.zero  = (x == '0);
    d.sign  = x[N-1];
    d.scale = (k <<< ES) + SCALE_W'(rem >> (N - 1 - ES));
    d.sig   = SIG_W'({1'b1, rem << ES} >> (ES + 2));
  end

endmodule

// File: rtl/posit_mul_pipe.sv
// 3-stage posit multiplier (decode / scale+multiply / normalise+round+encode), latency 3, one global stall enable.
// Rounding: POSIT_MUL_RNE_EN selects round-to-nearest-even; otherwise truncation toward zero.
module posit_mul_pipe
  import posit_pkg::*;
#(
  parameter int N  = 16,
  parameter int ES = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic [1:0]   out_flags
);

  localparam int SG = N - ES - 2;
  localparam int PW = 2 * SG;
  localparam int FW = PW - 1;
  localparam int TW = ES + FW + N;
  localparam int XW = 2 + TW;
  localparam logic signed [SCALE_W-1:0] MAX_SC = SCALE_W'((N - 2) << ES);
  localparam logic signed [SCALE_W-1:0] MIN_SC = -MAX_SC;
  localparam logic [SCALE_W-1:0]        E_MASK = SCALE_W'((1 << ES) - 1);

  logic en;
  dec_t dec_a, dec_b;

  logic s1_vld_q, s1_vld_d;
  dec_t s1_a_q, s1_a_d, s1_b_q, s1_b_d;

  logic                      s2_vld_q, s2_vld_d, s2_nar_q, s2_nar_d, s2_zero_q, s2_zero_d;
  logic                      s2_sign_q, s2_sign_d;
  logic signed [SCALE_W-1:0] s2_scale_q, s2_scale_d;
  logic [PW-1:0]             s2_prod_q, s2_prod_d, sig_a, sig_b;

  logic         s3_vld_q, s3_vld_d;
  logic [N-1:0] s3_data_q, s3_data_d;
  logic [1:0]   s3_flags_q, s3_flags_d;

  logic signed [SCALE_W-1:0] sc, kk;
  logic [SCALE_W-1:0]        amt, e_val;
  logic [FW-1:0]             frac;
  logic [TW-1:0]             tail;
  logic signed [XW-1:0]      xs;
  logic [XW-1:0]             sh_v;
  logic [N-2:0]              body;
  logic [N-1:0]              mag, res;
  logic                      sat;
`ifdef POSIT_MUL_RNE_EN
  logic                      guard, sticky;
`endif

  assign en        = !s3_vld_q || out_ready;
  assign in_ready  = en;
  assign out_valid = s3_vld_q;
  assign out_data  = s3_data_q;
  assign out_flags = s3_flags_q;

  posit_decode #(.N(N), .ES(ES)) u_dec_a (.x(in_a), .d(dec_a));
  posit_decode #(.N(N), .ES(ES)) u_dec_b (.x(in_b), .d(dec_b));

  always_comb begin
    s1_vld_d = s1_vld_q;
    s1_a_d   = s1_a_q;
    s1_b_d   = s1_b_q;
    if (en) begin
      s1_vld_d = in_valid;
      s1_a_d   = dec_a;
      s1_b_d   = dec_b;
    end
  end

  always_comb begin
    sig_a      = PW'(s1_a_q.sig);
    sig_b      = PW'(s1_b_q.sig);
    s2_vld_d   = s2_vld_q;
    s2_nar_d   = s2_nar_q;
    s2_zero_d  = s2_zero_q;
    s2_sign_d  = s2_sign_q;
    s2_scale_d = s2_scale_q;
    s2_prod_d  = s2_prod_q;
    if (en) begin
      s2_vld_d   = s1_vld_q;
      s2_nar_d   = s1_a_q.nar | s1_b_q.nar;
      s2_zero_d  = s1_a_q.zero | s1_b_q.zero;
      s2_sign_d  = s1_a_q.sign ^ s1_b_q.sign;
      s2_scale_d = s1_a_q.scale + s1_b_q.scale;
      s2_prod_d  = sig_a * sig_b;
    end
  end

  always_comb begin
    sc    = s2_scale_q + SCALE_W'(s2_prod_q[PW-1]);
    frac  = s2_prod_q[PW-1] ? s2_prod_q[PW-2:0] : {s2_prod_q[PW-3:0], 1'b0};
    kk    = sc >>> ES;
    amt   = kk[SCALE_W-1] ? ~kk : kk;
    e_val = sc & E_MASK;
    tail  = (TW'(e_val) << (FW + N)) | TW'({frac, {N{1'b0}}});
    // Arithmetic shift grows a ones-run for k>=0; for k<0 the top bit is 0 so zeros shift in.
    xs    = {kk[SCALE_W-1] ? 2'b01 : 2'b10, tail};
    sh_v  = xs >>> amt;
    body  = (N-1)'(sh_v >> (XW - N + 1));
`ifdef POSIT_MUL_RNE_EN
    guard  = sh_v[XW-N];
    sticky = |sh_v[XW-N-1:0];
    if (guard && (body[0] || sticky) && !(&body)) body = body + 1'b1;
`endif
    sat = 1'b0;
    if (sc > MAX_SC) begin
      body = (N-1)'(maxpos_pat(N));
      sat  = 1'b1;
    end else if (sc < MIN_SC) begin
      body = (N-1)'(minpos_pat(N));
      sat  = 1'b1;
    end
    mag = {1'b0, body};
    res = s2_sign_q ? -mag : mag;

    s3_vld_d   = s3_vld_q;
    s3_data_d  = s3_data_q;
    s3_flags_d = s3_flags_q;
    if (en) begin
      s3_vld_d = s2_vld_q;
      if (s2_nar_q) begin
        s3_data_d  = N'(nar_pat(N));
        s3_flags_d = 2'b01;
      end else if (s2_zero_q) begin
        s3_data_d  = '0;
        s3_flags_d = 2'b00;
      end else begin
        s3_data_d  = res;
        s3_flags_d = {sat, 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_vld_q   <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s2_vld_q   <= 1'b0;
      s2_nar_q   <= 1'b0;
      s2_zero_q  <= 1'b0;
      s2_sign_q  <= 1'b0;
      s2_scale_q <= '0;
      s2_prod_q  <= '0;
      s3_vld_q   <= 1'b0;
      s3_data_q  <= '0;
      s3_flags_q <= '0;
    end else begin
      s1_vld_q   <= s1_vld_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s2_vld_q   <= s2_vld_d;
      s2_nar_q   <= s2_nar_d;
      s2_zero_q  <= s2_zero_d;
      s2_sign_q  <= s2_sign_d;
      s2_scale_q <= s2_scale_d;
      s2_prod_q  <= s2_prod_d;
      s3_vld_q   <= s3_vld_d;
      s3_data_q  <= s3_data_d;
      s3_flags_q <= s3_flags_d;
    end
  end

endmodule
